// File: rtl/mc_pkg.sv
// Shared definitions for the RV32I multi-cycle controller: opcodes, FSM states,
// ALU operation encodings, datapath mux selects and the ALU decode helper.
package mc_pkg;

    localparam int OPCODE_W = 7;

    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_RTYPE  = 7'b0110011;
    localparam logic [6:0] OP_ITYPE  = 7'b0010011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;

    localparam logic [2:0] F3_BEQ  = 3'b000;
    localparam logic [2:0] F3_BNE  = 3'b001;
    localparam logic [2:0] F3_BLT  = 3'b100;
    localparam logic [2:0] F3_BGE  = 3'b101;
    localparam logic [2:0] F3_BLTU = 3'b110;
    localparam logic [2:0] F3_BGEU = 3'b111;
    localparam logic [2:0] F3_SR   = 3'b101;

    typedef enum logic [3:0] {
        S_FETCH, S_DECODE, S_MEMADR, S_MEMREAD, S_MEMWB, S_MEMWRITE, S_EXECR,
        S_EXECI, S_LUI, S_AUIPC, S_ALUWB, S_BRANCH, S_JALR, S_JAL, S_TRAP
    } state_t;

    typedef enum logic [3:0] {
        ALU_ADD  = 4'b0000, ALU_SUB = 4'b0001, ALU_AND = 4'b0010, ALU_OR  = 4'b0011,
        ALU_XOR  = 4'b0100, ALU_SLT = 4'b0101, ALU_SLTU = 4'b0110, ALU_SLL = 4'b0111,
        ALU_SRL  = 4'b1000, ALU_SRA = 4'b1001
    } alu_op_t;

    localparam logic [1:0] SRC_A_PC    = 2'b00;
    localparam logic [1:0] SRC_A_OLDPC = 2'b01;
    localparam logic [1:0] SRC_A_RS1   = 2'b10;
    localparam logic [1:0] SRC_A_ZERO  = 2'b11;

    localparam logic [1:0] SRC_B_RS2   = 2'b00;
    localparam logic [1:0] SRC_B_IMM   = 2'b01;
    localparam logic [1:0] SRC_B_FOUR  = 2'b10;

    localparam logic [1:0] RES_ALUOUT    = 2'b00;
    localparam logic [1:0] RES_RDATA     = 2'b01;
    localparam logic [1:0] RES_ALURESULT = 2'b10;

    // alt selects SUB/SRA; the caller decides when funct7b5 is meaningful
    function automatic alu_op_t alu_decode(input logic [2:0] funct3, input logic alt);
        case (funct3)
            3'b000:  return alt ? ALU_SUB : ALU_ADD;
            3'b001:  return ALU_SLL;
            3'b010:  return ALU_SLT;
            3'b011:  return ALU_SLTU;
            3'b100:  return ALU_XOR;
            3'b101:  return alt ? ALU_SRA : ALU_SRL;
            3'b110:  return ALU_OR;
            default: return ALU_AND;
        endcase
    endfunction

endpackage

// File: rtl/mc_branch_eval.sv
// Branch condition evaluation: maps funct3 and the ALU compare flags to a
// taken/not-taken decision. Reserved encodings 010/011 never take.
module mc_branch_eval
    import mc_pkg::*;
(
    input  logic [2:0] funct3,
    input  logic       zero,
    input  logic       lt_s,
    input  logic       lt_u,
    output logic       take
);

    always_comb begin
        take = 1'b0;
        case (funct3)
            F3_BEQ:  take = zero;
            F3_BNE:  take = !zero;
            F3_BLT:  take = lt_s;
            F3_BGE:  take = !lt_s;
            F3_BLTU: take = lt_u;
            F3_BGEU: take = !lt_u;
            default: take = 1'b0;
        endcase
    end

endmodule

// File: rtl/multicycle_controller.sv
// Multi-cycle RV32I sequencer: Moore FSM driving shared ALU/memory selects,
// with a retired-instruction counter. Define MC_ILLEGAL_TRAP_EN for the trap state.
//
// state    | meaning
// FETCH    | read instruction at PC, PC <= PC+4 when memory is ready
// DECODE   | ALUOut <= OldPC+imm (branch/JAL target), dispatch on opcode
// MEMADR   | ALUOut <= rs1+imm
// MEMREAD  | load access at ALUOut, wait for mem_ready
// MEMWB    | write load data to rd
// MEMWRITE | store access at ALUOut, wait for mem_ready
// EXECR    | register-register ALU op
// EXECI    | register-immediate ALU op
// LUI      | 0+imm
// AUIPC    | OldPC+imm
// ALUWB    | write ALUOut to rd
// BRANCH   | compare rs1/rs2, load target into PC if taken
// JALR     | ALUOut <= rs1+imm
// JAL      | PC <= ALUOut, ALUOut <= OldPC+4
// TRAP     | illegal opcode seen, parked until reset
module multicycle_controller
    import mc_pkg::*;
#(
    parameter int CNT_W = 32
) (
    input  logic                clk,
    input  logic                reset,
    input  logic [OPCODE_W-1:0] op,
    input  logic [2:0]          funct3,
    input  logic                funct7b5,
    input  logic                Zero,
    input  logic                LessThanS,
    input  logic                LessThanU,
    input  logic                mem_ready,
    output logic                PCWrite,
    output logic                AdrSrc,
    output logic                MemWrite,
    output logic                IRWrite,
    output logic [1:0]          ResultSrc,
    output logic [1:0]          ALUSrcA,
    output logic [1:0]          ALUSrcB,
    output logic [3:0]          ALUControl,
    output logic                RegWrite,
    output logic [2:0]          LoadType,
    output logic                instr_done,
    output logic [CNT_W-1:0]    instret
`ifdef MC_ILLEGAL_TRAP_EN
    ,
    output logic                illegal_instr
`endif
);

    state_t state, state_next;
    logic   take;

    mc_branch_eval u_branch_eval (
        .funct3 (funct3),
        .zero   (Zero),
        .lt_s   (LessThanS),
        .lt_u   (LessThanU),
        .take   (take)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) state <= S_FETCH;
        else       state <= state_next;
    end

    always_comb begin
        state_next = state;
        PCWrite    = 1'b0;
        AdrSrc     = 1'b0;
        MemWrite   = 1'b0;
        IRWrite    = 1'b0;
        ResultSrc  = RES_ALUOUT;
        ALUSrcA    = SRC_A_PC;
        ALUSrcB    = SRC_B_RS2;
        ALUControl = ALU_ADD;
        RegWrite   = 1'b0;
        LoadType   = 3'b000;
        instr_done = 1'b0;
        case (state)
            S_FETCH: begin
                ALUSrcB   = SRC_B_FOUR;
                ResultSrc = RES_ALURESULT;
                IRWrite   = mem_ready;
                PCWrite   = mem_ready;
                if (mem_ready) state_next = S_DECODE;
            end
            S_DECODE: begin
                ALUSrcA = SRC_A_OLDPC;
                ALUSrcB = SRC_B_IMM;
                case (op)
                    OP_LOAD, OP_STORE: state_next = S_MEMADR;
                    OP_RTYPE:          state_next = S_EXECR;
                    OP_ITYPE:          state_next = S_EXECI;
                    OP_BRANCH:         state_next = S_BRANCH;
                    OP_JAL:            state_next = S_JAL;
                    OP_JALR:           state_next = S_JALR;
                    OP_LUI:            state_next = S_LUI;
                    OP_AUIPC:          state_next = S_AUIPC;
`ifdef MC_ILLEGAL_TRAP_EN
                    default:           state_next = S_TRAP;
`else
                    default:           state_next = S_FETCH;
`endif
                endcase
            end
            S_MEMADR: begin
                ALUSrcA    = SRC_A_RS1;
                ALUSrcB    = SRC_B_IMM;
                state_next = op[5] ? S_MEMWRITE : S_MEMREAD;
            end
            S_MEMREAD: begin
                AdrSrc = 1'b1;
                if (mem_ready) state_next = S_MEMWB;
            end
            S_MEMWB: begin
                ResultSrc  = RES_RDATA;
                RegWrite   = 1'b1;
                LoadType   = funct3;
                instr_done = 1'b1;
                state_next = S_FETCH;
            end
            S_MEMWRITE: begin
                AdrSrc   = 1'b1;
                MemWrite = 1'b1;
                if (mem_ready) begin
                    instr_done = 1'b1;
                    state_next = S_FETCH;
                end
            end
            S_EXECR: begin
                ALUSrcA    = SRC_A_RS1;
                ALUSrcB    = SRC_B_RS2;
                ALUControl = alu_decode(funct3, funct7b5);
                state_next = S_ALUWB;
            end
            S_EXECI: begin
                // bit 30 is part of the immediate except for SRLI/SRAI
                ALUSrcA    = SRC_A_RS1;
                ALUSrcB    = SRC_B_IMM;
                ALUControl = alu_decode(funct3, funct7b5 && (funct3 == F3_SR));
                state_next = S_ALUWB;
            end
            S_LUI: begin
                ALUSrcA    = SRC_A_ZERO;
                ALUSrcB    = SRC_B_IMM;
                state_next = S_ALUWB;
            end
            S_AUIPC: begin
                ALUSrcA    = SRC_A_OLDPC;
                ALUSrcB    = SRC_B_IMM;
                state_next = S_ALUWB;
            end
            S_ALUWB: begin
                RegWrite   = 1'b1;
                instr_done = 1'b1;
                state_next = S_FETCH;
            end
            S_BRANCH: begin
                ALUSrcA    = SRC_A_RS1;
                ALUSrcB    = SRC_B_RS2;
                ALUControl = ALU_SUB;
                PCWrite    = take;
                instr_done = 1'b1;
                state_next = S_FETCH;
            end
            S_JALR: begin
                ALUSrcA    = SRC_A_RS1;
                ALUSrcB    = SRC_B_IMM;
                state_next = S_JAL;
            end
            S_JAL: begin
                ALUSrcA    = SRC_A_OLDPC;
                ALUSrcB    = SRC_B_FOUR;
                PCWrite    = 1'b1;
                state_next = S_ALUWB;
            end
            default: begin
`ifdef MC_ILLEGAL_TRAP_EN
                state_next = S_TRAP;
`else
                state_next = S_FETCH;
`endif
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset)           instret <= '0;
        else if (instr_done) instret <= instret + CNT_W'(1);
    end

`ifdef MC_ILLEGAL_TRAP_EN
    assign illegal_instr = (state == S_TRAP);
`endif

endmodule

// File: tb/tb_multicycle_controller.sv
// Self-checking bench for multicycle_controller: directed cases plus a random
// instruction stream scored against per-instruction expectations.
module tb_multicycle_controller;

    localparam logic [6:0] LOAD   = 7'b0000011;
    localparam logic [6:0] STORE  = 7'b0100011;
    localparam logic [6:0] RTYPE  = 7'b0110011;
    localparam logic [6:0] ITYPE  = 7'b0010011;
    localparam logic [6:0] BRANCH = 7'b1100011;
    localparam logic [6:0] JAL    = 7'b1101111;
    localparam logic [6:0] JALR   = 7'b1100111;
    localparam logic [6:0] LUI    = 7'b0110111;
    localparam logic [6:0] AUIPC  = 7'b0010111;

    logic        clk = 1'b0;
    logic        reset;
    logic [6:0]  op;
    logic [2:0]  funct3;
    logic        funct7b5, Zero, LessThanS, LessThanU, mem_ready;
    logic        PCWrite, AdrSrc, MemWrite, IRWrite, RegWrite, instr_done;
    logic [1:0]  ResultSrc, ALUSrcA, ALUSrcB;
    logic [3:0]  ALUControl;
    logic [2:0]  LoadType;
    logic [31:0] instret;
`ifdef MC_ILLEGAL_TRAP_EN
    logic        illegal_instr;
`endif

    int          checks = 0;
    int          failures = 0;
    logic [31:0] model_instret = 0;

    multicycle_controller #(.CNT_W(32)) dut (
        .clk(clk), .reset(reset), .op(op), .funct3(funct3), .funct7b5(funct7b5),
        .Zero(Zero), .LessThanS(LessThanS), .LessThanU(LessThanU), .mem_ready(mem_ready),
        .PCWrite(PCWrite), .AdrSrc(AdrSrc), .MemWrite(MemWrite), .IRWrite(IRWrite),
        .ResultSrc(ResultSrc), .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB), .ALUControl(ALUControl),
        .RegWrite(RegWrite), .LoadType(LoadType), .instr_done(instr_done), .instret(instret)
`ifdef MC_ILLEGAL_TRAP_EN
        , .illegal_instr(illegal_instr)
`endif
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            failures++;
            $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // ALU op table indexed by funct3: ADD SLL SLT SLTU XOR SRL OR AND
    function automatic logic [3:0] ref_alu(input logic [2:0] f3, input logic alt);
        logic [3:0] tbl [8];
        tbl = '{4'd0, 4'd7, 4'd5, 4'd6, 4'd4, 4'd8, 4'd3, 4'd2};
        if (alt && f3 == 3'd0) return 4'd1;
        if (alt && f3 == 3'd5) return 4'd9;
        return tbl[f3];
    endfunction

    function automatic logic ref_take(input logic [2:0] f3, input logic z, input logic ls,
                                      input logic lu);
        case (f3)
            3'd0: return z;
            3'd1: return !z;
            3'd4: return ls;
            3'd5: return !ls;
            3'd6: return lu;
            3'd7: return !lu;
            default: return 1'b0;
        endcase
    endfunction

    // Runs one instruction from FETCH back to FETCH. fs = fetch stall cycles,
    // ms = data-memory stall cycles. Expectations come from per-class rules.
    task automatic run_instr(input string name, input logic [6:0] o, input logic [2:0] f3,
                             input logic f7, input logic z, input logic ls, input logic lu,
                             input int fs, input int ms);
        int cyc = 0, fw = 0, mwait = 0;
        int rw = 0, mw = 0, pcw = 0, irw = 0, adr = 0, dn = 0, lt_stray = 0;
        bit left = 0, fin = 0;
        logic [3:0] alu_rs1 = 4'hF;
        logic [1:0] res_rw = 2'b11;
        logic [2:0] lt_rw = 3'b000;
        int e_lat, e_rw, e_mw, e_pcw, e_adr, e_dn;
        logic [3:0] e_alu;
        logic [1:0] e_res;
        logic [2:0] e_lt;

        op = o; funct3 = f3; funct7b5 = f7; Zero = z; LessThanS = ls; LessThanU = lu;
        while (!fin && cyc < 60) begin
            if (ResultSrc == 2'b10 && left) begin
                fin = 1;
            end else begin
                if (ResultSrc == 2'b10) begin
                    mem_ready = (fw >= fs); fw++;
                end else if (AdrSrc) begin
                    mem_ready = (mwait >= ms); mwait++;
                end else begin
                    mem_ready = 1'($urandom_range(0, 1));
                end
                #1;
                if (ResultSrc != 2'b10) left = 1;
                cyc++;
                if (RegWrite) begin rw++; res_rw = ResultSrc; lt_rw = LoadType; end
                if (MemWrite) mw++;
                if (PCWrite) pcw++;
                if (IRWrite) irw++;
                if (AdrSrc) adr++;
                if (instr_done) dn++;
                if (ALUSrcA == 2'b10) alu_rs1 = ALUControl;
                if (LoadType != 3'b000 && ResultSrc != 2'b01) lt_stray++;
                @(negedge clk);
            end
        end
        check({name, "_timeout"}, 32'(fin), 32'd1);

        e_rw = 1; e_mw = 0; e_pcw = 1; e_adr = 0; e_dn = 1;
        e_alu = 4'hF; e_res = 2'b00; e_lt = 3'b000;
        case (o)
            LOAD:   begin e_lat = 5 + ms; e_adr = 1 + ms; e_alu = 4'd0; e_res = 2'b01; e_lt = f3; end
            STORE:  begin e_lat = 4 + ms; e_adr = 1 + ms; e_mw = 1 + ms; e_rw = 0; e_alu = 4'd0; end
            RTYPE:  begin e_lat = 4; e_alu = ref_alu(f3, f7); end
            ITYPE:  begin e_lat = 4; e_alu = ref_alu(f3, f7 && f3 == 3'd5); end
            BRANCH: begin e_lat = 3; e_rw = 0; e_alu = 4'd1; e_pcw = 1 + int'(ref_take(f3, z, ls, lu)); end
            JAL:    begin e_lat = 4; e_pcw = 2; end
            JALR:   begin e_lat = 5; e_pcw = 2; e_alu = 4'd0; end
            LUI, AUIPC: e_lat = 4;
            default: begin e_lat = 2; e_rw = 0; e_dn = 0; end
        endcase
        e_lat += fs;
        model_instret += 32'(e_dn);

        check({name, "_cycles"},   32'(cyc), 32'(e_lat));
        check({name, "_regwrite"}, 32'(rw),  32'(e_rw));
        check({name, "_memwrite"}, 32'(mw),  32'(e_mw));
        check({name, "_pcwrite"},  32'(pcw), 32'(e_pcw));
        check({name, "_irwrite"},  32'(irw), 32'd1);
        check({name, "_adrsrc"},   32'(adr), 32'(e_adr));
        check({name, "_done"},     32'(dn),  32'(e_dn));
        check({name, "_aluctl"},   32'(alu_rs1), 32'(e_alu));
        check({name, "_lt_stray"}, 32'(lt_stray), 32'd0);
        check({name, "_instret"},  instret, model_instret);
        if (e_rw != 0) begin
            check({name, "_wb_result"}, 32'(res_rw), 32'(e_res));
            check({name, "_wb_loadtype"}, 32'(lt_rw), 32'(e_lt));
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired got=running exp=finished");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [6:0] ops [10];
        int n_ops;
        int k;
        ops = '{LOAD, STORE, RTYPE, ITYPE, BRANCH, JAL, JALR, LUI, AUIPC, 7'b0000000};
`ifdef MC_ILLEGAL_TRAP_EN
        n_ops = 9;
`else
        n_ops = 10;
`endif
        reset = 1'b1; op = 7'd0; funct3 = 3'd0; funct7b5 = 1'b0;
        Zero = 1'b0; LessThanS = 1'b0; LessThanU = 1'b0; mem_ready = 1'b0;
        repeat (2) @(negedge clk);
        #1;
        check("rst_fetch",    32'(ResultSrc), 32'd2);
        check("rst_instret",  instret, 32'd0);
        check("rst_memwrite", 32'(MemWrite), 32'd0);
        check("rst_regwrite", 32'(RegWrite), 32'd0);
        check("rst_pcwrite",  32'(PCWrite), 32'd0);
        check("rst_done",     32'(instr_done), 32'd0);
        @(negedge clk);
        reset = 1'b0;

        run_instr("addi", ITYPE, 3'b000, 1'b1, 0, 0, 0, 0, 0);
        run_instr("lw",   LOAD,  3'b010, 1'b0, 0, 0, 0, 0, 3);
        run_instr("sw",   STORE, 3'b010, 1'b0, 0, 0, 0, 0, 2);
        run_instr("beq_t", BRANCH, 3'b000, 1'b0, 1, 0, 0, 0, 0);
        run_instr("beq_n", BRANCH, 3'b000, 1'b0, 0, 0, 0, 0, 0);
        run_instr("bltu",  BRANCH, 3'b110, 1'b0, 0, 0, 1, 0, 0);
        run_instr("bgeu",  BRANCH, 3'b111, 1'b0, 0, 0, 1, 0, 0);
        run_instr("jalr",  JALR,  3'b000, 1'b0, 0, 0, 0, 0, 0);
        run_instr("sub",   RTYPE, 3'b000, 1'b1, 0, 0, 0, 1, 0);
        run_instr("srai",  ITYPE, 3'b101, 1'b1, 0, 0, 0, 2, 0);

        // reset while a store is waiting on memory
        op = STORE; funct3 = 3'b010; k = 0;
        while (!AdrSrc && k < 12) begin
            mem_ready = (ResultSrc == 2'b10);
            @(negedge clk);
            k++;
        end
        mem_ready = 1'b0;
        #1;
        check("abort_in_memwrite", 32'(MemWrite), 32'd1);
        #1 reset = 1'b1;
        #1;
        check("abort_memwrite", 32'(MemWrite), 32'd0);
        check("abort_regwrite", 32'(RegWrite), 32'd0);
        check("abort_fetch",    32'(ResultSrc), 32'd2);
        check("abort_instret",  instret, 32'd0);
        model_instret = 0;
        @(negedge clk);
        reset = 1'b0;

`ifdef MC_ILLEGAL_TRAP_EN
        op = 7'b0000000; mem_ready = 1'b1;
        repeat (5) @(negedge clk);
        #1;
        check("trap_flag",     32'(illegal_instr), 32'd1);
        check("trap_pcwrite",  32'(PCWrite), 32'd0);
        check("trap_irwrite",  32'(IRWrite), 32'd0);
        check("trap_regwrite", 32'(RegWrite), 32'd0);
        check("trap_instret",  instret, model_instret);
        reset = 1'b1;
        #1;
        check("trap_clear", 32'(illegal_instr), 32'd0);
        @(negedge clk);
        reset = 1'b0;
`else
        run_instr("illegal", 7'b0000000, 3'b000, 1'b0, 0, 0, 0, 1, 0);
`endif

        for (int i = 0; i < 80; i++) begin
            run_instr("rnd", ops[$urandom_range(0, n_ops - 1)], 3'($urandom_range(0, 7)),
                      1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                      1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                      int'($urandom_range(0, 2)), int'($urandom_range(0, 3)));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/multicycle_controller.md
Name: multicycle_controller

Overview:
Multi-cycle sequencer for the RV32I core. It shares one ALU and one unified memory port across fetch, address, execute and writeback steps. Each instruction is walked through a Moore FSM that drives mux selects, write enables and ALU operation. Memory accesses stall on a ready handshake, and the block counts retired instructions.

Parameters:
CNT_W, 32, width of retired-instruction counter
OPCODE_W, 7, opcode field width (fixed, not for override)

Ports:
clk  in  1  core clock
reset  in  1  asynchronous, active-high reset
op  in  7  instruction opcode (from IR)
funct3  in  3  instruction funct3
funct7b5  in  1  instruction bit 30
Zero  in  1  ALU compare: equal
LessThanS  in  1  ALU compare: signed less-than
LessThanU  in  1  ALU compare: unsigned less-than
mem_ready  in  1  memory completes current access this cycle
PCWrite  out  1  PC register enable
AdrSrc  out  1  memory address: 0 = PC, 1 = ALUOut
MemWrite  out  1  memory write strobe
IRWrite  out  1  IR/OldPC register enable
ResultSrc  out  2  00 = ALUOut, 01 = read data, 10 = ALUResult
ALUSrcA  out  2  00 = PC, 01 = OldPC, 10 = rs1 reg, 11 = zero
ALUSrcB  out  2  00 = rs2 reg, 01 = ImmExt, 10 = const 4
ALUControl  out  4  ALU operation (package encoding)
RegWrite  out  1  register-file write enable
LoadType  out  3  funct3 during MEMWB, else 000
instr_done  out  1  one-cycle pulse when an instruction retires
instret  out  CNT_W  retired-instruction count

Behaviour:
- All outputs decode from the state register. PCWrite, IRWrite and the branch decision are additionally gated by inputs.
- Reset: state = FETCH; instret = 0. Reset mid-instruction aborts immediately. MemWrite and RegWrite drop to 0 asynchronously. No partial writeback.
- Selects not listed for a state are 0. ALUControl defaults to ADD.
- FETCH: AdrSrc=0, A=00, B=10, ADD, ResultSrc=10. IRWrite = PCWrite = mem_ready. Stays in FETCH while mem_ready=0, else goes to DECODE.
- DECODE: A=01, B=01, ADD; ALUOut holds the branch/JAL target. Next state by op:
  - 0000011/0100011 -> MEMADR
  - 0110011 -> EXECR
  - 0010011 -> EXECI
  - 1100011 -> BRANCH
  - 1101111 -> JAL
  - 1100111 -> JALR
  - 0110111 -> LUI
  - 0010111 -> AUIPC
  - any other -> FETCH, no retire (see option).
- MEMADR: A=10, B=01, ADD. Goes to MEMREAD if op[5]=0, else MEMWRITE.
- MEMREAD: AdrSrc=1. Waits for mem_ready, then MEMWB.
- MEMWB: ResultSrc=01, RegWrite=1, LoadType=funct3. Goes to FETCH.
- MEMWRITE: AdrSrc=1, MemWrite=1, held until mem_ready. Goes to FETCH.
- EXECR: A=10, B=00. ALU op from funct3 plus funct7b5. Goes to ALUWB.
- EXECI: A=10, B=01. funct7b5 honoured only for funct3=101 (SRAI); otherwise ignored (ADDI never SUB). Goes to ALUWB.
- LUI: A=11, B=01, ADD. Goes to ALUWB.
- AUIPC: A=01, B=01, ADD. Goes to ALUWB.
- ALUWB: ResultSrc=00, RegWrite=1. Goes to FETCH.
- BRANCH: A=10, B=00, SUB, ResultSrc=00. PCWrite = take, where take is decided by funct3:
  - 000: Zero
  - 001: !Zero
  - 100: LessThanS
  - 101: !LessThanS
  - 110: LessThanU
  - 111: !LessThanU
  - 010/011: 0
  Goes to FETCH.
- JALR: A=10, B=01, ADD; the datapath clears bit 0. Goes to JAL.
- JAL: A=01, B=10, ADD, ResultSrc=00, PCWrite=1. Goes to ALUWB, which writes OldPC+4.
- instr_done = 1 on the transition into FETCH from MEMWB, MEMWRITE (with mem_ready), ALUWB or BRANCH. instret increments on the same edge and wraps to 0 at 2^CNT_W.
- Latency (all-ready memory):
  - R/I/LUI/AUIPC: 4 cycles
  - load: 5
  - store: 4
  - branch: 3
  - JAL: 4
  - JALR: 5

Optional Feature:
MC_ILLEGAL_TRAP_EN
- Defined: adds output illegal_instr (1 bit, reset 0) and state TRAP. An unknown opcode in DECODE goes to TRAP. TRAP asserts illegal_instr and holds all enables at 0 until reset.
- Undefined: an unknown opcode returns to FETCH as a NOP with no instr_done and no instret increment. The port is absent.

Decomposition:
- Package mc_pkg holds:
  - opcode localparams
  - state enum (4-bit)
  - ALUControl encodings: ADD=0000, SUB=0001, AND=0010, OR=0011, XOR=0100, SLT=0101, SLTU=0110, SLL=0111, SRL=1000, SRA=1001
  - mux-select constants
- Sub-module mc_branch_eval: combinational funct3 plus flags -> take.

Test Plan:
- addi x1,x0,5 with mem_ready tied 1 -> FETCH, DECODE, EXECI, ALUWB. RegWrite=1 only in cycle 4, ALUControl=ADD, instret 0->1.
- lw with mem_ready=0 for 3 cycles in MEMREAD -> AdrSrc=1 held 4 cycles. MEMWB RegWrite=1, LoadType=010. Total 8 cycles.
- sw with mem_ready low 2 cycles -> MemWrite high exactly 3 cycles. RegWrite never 1.
- beq with Zero=1 -> PCWrite=1 in BRANCH, ResultSrc=00. With Zero=0 -> PCWrite=0. bltu/bgeu with LessThanU=1 -> take 1/0.
- jalr -> states JALR, JAL, ALUWB. PCWrite=1 in JAL, RegWrite=1 in ALUWB, instret +1.
- Reset asserted during MEMWRITE -> MemWrite=0 the same cycle, state FETCH, instret=0. Opcode 0000000 -> FETCH without retire, or TRAP with illegal_instr=1 under MC_ILLEGAL_TRAP_EN.
